// File: rtl/spi_periph_pkg.sv
// Shared definitions for the SPI register-file peripheral: FSM encoding,
// frame-field position helpers and the error counter width.
package spi_periph_pkg;

  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_OVF
  } state_e;

  // Frame layout, MSB first on the wire: {rw, addr, data}
  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int unsigned rw_pos(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + data_w;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with optional
// rise/fall detection taken against one extra delay flop.
module spi_in_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0,
  parameter bit          EDGES   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

  if (EDGES) begin : g_edge
    logic dly_q;

    always_ff @(posedge clk) begin
      if (rst) dly_q <= RST_VAL;
      else     dly_q <= q_o;
    end

    assign rise_o = q_o & ~dly_q;
    assign fall_o = ~q_o & dly_q;
  end else begin : g_no_edge
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
  end

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral: register file written/read by fixed-length frames,
// committed only on a clean CS release, with malformed frames counted.
module spi_regfile_periph
  import spi_periph_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk_raw,
  input  logic                         mosi_raw,
  input  logic                         cs_n_raw,
  output logic                         miso,
  output logic                         miso_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [ERR_CNT_W-1:0]         frame_err_cnt
);

  localparam int unsigned FRAME_W  = frame_w(ADDR_W, DATA_W);
  localparam int unsigned BC_W     = $clog2(FRAME_W + 1);
  localparam int unsigned HDR_RW   = rw_pos(ADDR_W, 0);
  localparam int unsigned FRM_RW   = rw_pos(ADDR_W, DATA_W);
  localparam int unsigned FRM_ADDR = addr_lsb(DATA_W);

  logic       unused_sclk_lvl;
  logic [1:0] unused_mosi_edges;
  logic       sclk_rise, sclk_fall;
  logic       mosi_s;
  logic       cs_n_s, cs_rise, cs_fall;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(sclk_raw),
    .q_o(unused_sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(mosi_raw),
    .q_o(mosi_s), .rise_o(unused_mosi_edges[0]), .fall_o(unused_mosi_edges[1])
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGES(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(cs_n_raw),
    .q_o(cs_n_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  state_e                       state_q;
  logic [FRAME_W-1:0]           shift_q;
  logic [FRAME_W-1:0]           shift_c;
  logic [BC_W-1:0]              bit_cnt_q;
  logic                         rw_q;
  logic [DATA_W-1:0]            tx_q;
  logic [NUM_REGS*DATA_W-1:0]   regs_q;
  logic                         miso_q, miso_oe_q, wr_strobe_q;
  logic [ADDR_W-1:0]            wr_addr_q;
  logic [ERR_CNT_W-1:0]         err_cnt_q;
  logic [DATA_W-1:0]            rd_data_c;
  logic                         wr_hit_c;

  assign shift_c = {shift_q[FRAME_W-2:0], mosi_s};

  // Read lookup on the address as it completes; out-of-range reads return 0
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shift_c[ADDR_W-1:0] == ADDR_W'(i)) rd_data_c = regs_q[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    wr_hit_c = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shift_q[FRM_ADDR +: ADDR_W] == ADDR_W'(i)) wr_hit_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rw_q        <= 1'b0;
      tx_q        <= '0;
      regs_q      <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      miso_oe_q   <= ~cs_n_s;

      // CS release outranks any SCLK edge seen in the same cycle
      if (state_q != ST_IDLE && cs_rise) begin
        state_q <= ST_IDLE;
        miso_q  <= 1'b0;
        if (state_q == ST_DONE) begin
          if (shift_q[FRM_RW] && wr_hit_c) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (shift_q[FRM_ADDR +: ADDR_W] == ADDR_W'(i))
                regs_q[i*DATA_W +: DATA_W] <= shift_q[DATA_W-1:0];
            end
            wr_strobe_q <= 1'b1;
            wr_addr_q   <= shift_q[FRM_ADDR +: ADDR_W];
          end
        end else if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cs_fall) begin
              state_q   <= ST_ADDR;
              shift_q   <= '0;
              bit_cnt_q <= '0;
              rw_q      <= 1'b0;
              tx_q      <= '0;
              miso_q    <= 1'b0;
            end
          end
          ST_ADDR: begin
            if (sclk_rise) begin
              shift_q <= shift_c;
              if (bit_cnt_q == BC_W'(ADDR_W)) begin
                state_q   <= ST_DATA;
                bit_cnt_q <= '0;
                rw_q      <= shift_c[HDR_RW];
                tx_q      <= shift_c[HDR_RW] ? '0 : rd_data_c;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              shift_q <= shift_c;
              if (bit_cnt_q == BC_W'(DATA_W - 1)) state_q <= ST_DONE;
              else                                 bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (sclk_fall && !rw_q) begin
              miso_q <= tx_q[DATA_W-1];
              tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
            end
          end
          ST_DONE: begin
            if (sclk_rise) state_q <= ST_OVF;
          end
          ST_OVF: begin
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign miso          = miso_q;
  assign miso_oe       = miso_oe_q;
  assign regs_flat     = regs_q;
  assign wr_strobe     = wr_strobe_q;
  assign wr_addr       = wr_addr_q;
  assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Bench for spi_regfile_periph: directed frame table, hand-written corner
// sequences, then random frames against a register/counter model.
module tb_spi_regfile_periph;

  localparam int unsigned HALF = 5;
  localparam int unsigned GAP  = 20;
  localparam int unsigned NREG = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk_raw, mosi_raw, cs_n_raw;
  logic        miso, miso_oe, wr_strobe;
  logic [39:0] regs_flat;
  logic [6:0]  wr_addr;
  logic [7:0]  frame_err_cnt;

  spi_regfile_periph dut (
    .clk(clk), .rst(rst),
    .sclk_raw(sclk_raw), .mosi_raw(mosi_raw), .cs_n_raw(cs_n_raw),
    .miso(miso), .miso_oe(miso_oe), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err_cnt(frame_err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;
  int cs_rise_cyc = 0;
  logic last_oe;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_cyc = cyc;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Full SPI transaction: nbits of 'bits' MSB first; MISO sampled before each rise
  task automatic spi_frame(input logic [23:0] bits, input int nbits, output logic [23:0] rx);
    rx = '0;
    @(negedge clk) cs_n_raw = 1'b0;
    repeat (HALF) @(negedge clk);
    last_oe = miso_oe;
    for (int i = 0; i < nbits; i++) begin
      mosi_raw = bits[nbits-1-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[22:0], miso};
      sclk_raw = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk_raw = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n_raw    = 1'b1;
    cs_rise_cyc = cyc;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cs_n_raw = 1'b1; sclk_raw = 1'b0; mosi_raw = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  typedef struct {
    logic [23:0] bits;
    int          nbits;
    logic [39:0] exp_regs;
    int          exp_err;
    int          exp_strobes;
    logic [6:0]  exp_waddr;
    logic        chk_rd;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[6];

  logic [7:0] m_regs[NREG];
  int         m_err;

  function automatic logic [39:0] model_flat();
    logic [39:0] f;
    for (int i = 0; i < NREG; i++) f[i*8 +: 8] = m_regs[i];
    return f;
  endfunction

  initial begin
    logic [23:0] rx;
    logic [23:0] bits;
    int          nbits, s0, exp_str;
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  data, exp_rd;

    vecs[0] = '{24'h0082A5, 16, 40'h0000A50000, 0, 1, 7'd2, 1'b0, 8'h00};
    vecs[1] = '{24'h000200, 16, 40'h0000A50000, 0, 0, 7'd0, 1'b1, 8'hA5};
    vecs[2] = '{24'h000813, 12, 40'h0000A50000, 1, 0, 7'd0, 1'b0, 8'h00};
    vecs[3] = '{24'h01054B, 17, 40'h0000A50000, 2, 0, 7'd0, 1'b0, 8'h00};
    vecs[4] = '{24'h0090FF, 16, 40'h0000A50000, 2, 0, 7'd0, 1'b0, 8'h00};
    vecs[5] = '{24'h000700, 16, 40'h0000A50000, 2, 0, 7'd0, 1'b1, 8'h00};

    rst = 1'b1; cs_n_raw = 1'b1; sclk_raw = 1'b0; mosi_raw = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_regs", 64'(regs_flat), 64'h0);
    check("reset_miso", 64'(miso), 64'h0);
    check("reset_oe", 64'(miso_oe), 64'h0);
    check("reset_strobe", 64'(wr_strobe), 64'h0);
    check("reset_waddr", 64'(wr_addr), 64'h0);
    check("reset_err", 64'(frame_err_cnt), 64'h0);
    rst = 1'b0;
    repeat (GAP) @(negedge clk);

    // Directed frames
    for (int v = 0; v < 6; v++) begin
      s0 = strobe_cnt;
      spi_frame(vecs[v].bits, vecs[v].nbits, rx);
      check($sformatf("vec%0d_oe", v), 64'(last_oe), 64'h1);
      check($sformatf("vec%0d_regs", v), 64'(regs_flat), 64'(vecs[v].exp_regs));
      check($sformatf("vec%0d_err", v), 64'(frame_err_cnt), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_strobes", v), 64'(strobe_cnt - s0), 64'(vecs[v].exp_strobes));
      if (vecs[v].chk_rd) check($sformatf("vec%0d_rd", v), 64'(rx[7:0]), 64'(vecs[v].exp_rd));
      if (vecs[v].exp_strobes == 1) begin
        check($sformatf("vec%0d_waddr", v), 64'(wr_addr), 64'(vecs[v].exp_waddr));
        check($sformatf("vec%0d_strobe_lat", v), 64'(strobe_cyc - cs_rise_cyc), 64'd3);
      end
    end
    check("idle_oe", 64'(miso_oe), 64'h0);
    check("idle_miso", 64'(miso), 64'h0);

    // Error counter saturation
    m_err = 2;
    for (int k = 1; k <= 260; k++) begin
      spi_frame(24'h1, 1, rx);
      m_err = (m_err == 255) ? 255 : m_err + 1;
      if (k == 252 || k == 253 || k == 260)
        check($sformatf("sat_err_%0d", k), 64'(frame_err_cnt), 64'(m_err));
    end

    // Reset in the middle of a frame
    @(negedge clk) cs_n_raw = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      mosi_raw = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk_raw = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk_raw = 1'b0;
    end
    s0 = strobe_cnt;
    do_reset();
    check("midrst_regs", 64'(regs_flat), 64'h0);
    check("midrst_err", 64'(frame_err_cnt), 64'h0);
    spi_frame(24'h00843C, 16, rx);
    check("midrst_wr_regs", 64'(regs_flat), 64'h3C00000000);
    check("midrst_wr_err", 64'(frame_err_cnt), 64'h0);
    check("midrst_wr_waddr", 64'(wr_addr), 64'h4);
    check("midrst_strobes", 64'(strobe_cnt - s0), 64'h1);

    // Back-to-back writes with a two-SCLK CS gap
    s0 = strobe_cnt;
    spi_frame(24'h008011, 16, rx);
    spi_frame(24'h008122, 16, rx);
    check("b2b_regs", 64'(regs_flat), 64'h3C00002211);
    check("b2b_strobes", 64'(strobe_cnt - s0), 64'h2);
    check("b2b_waddr", 64'(wr_addr), 64'h1);
    check("b2b_err", 64'(frame_err_cnt), 64'h0);

    // Random frames against the model
    do_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_err = 0;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        nbits = $urandom_range(1, 24);
        bits  = 24'($urandom());
      end else begin
        nbits = 16;
        bits  = {8'h00, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom())};
      end
      exp_str = 0;
      exp_rd  = 8'h00;
      rw      = bits[15];
      addr    = bits[14:8];
      data    = bits[7:0];
      if (nbits == 16) begin
        if (!rw && addr < NREG) exp_rd = m_regs[addr];
        if (rw && addr < NREG) begin
          m_regs[addr] = data;
          exp_str      = 1;
        end
      end else begin
        m_err = (m_err == 255) ? 255 : m_err + 1;
      end
      s0 = strobe_cnt;
      spi_frame(bits, nbits, rx);
      check($sformatf("rnd%0d_regs", t), 64'(regs_flat), 64'(model_flat()));
      check($sformatf("rnd%0d_err", t), 64'(frame_err_cnt), 64'(m_err));
      check($sformatf("rnd%0d_strobes", t), 64'(strobe_cnt - s0), 64'(exp_str));
      if (nbits == 16 && !rw) check($sformatf("rnd%0d_rd", t), 64'(rx[7:0]), 64'(exp_rd));
      if (exp_str == 1) check($sformatf("rnd%0d_waddr", t), 64'(wr_addr), 64'(addr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
